piezo_seq: RTL and testbench
============================

PIEZO_SEQ -- requirements
Module: piezo_seq

Interface
REQ-001 SHALL provide parameter NUM_CH, default 3: number of alarm channels; index 0 is highest priority.
REQ-002 SHALL provide parameter CNT_W, default 21: width of each tone-period field.
REQ-003 SHALL provide parameter PAT_LEN, default 8: cadence steps per pattern (power of two).
REQ-004 SHALL provide parameter TICK_CNT, default 6250000: clocks per cadence step (125 ms at 50 MHz).
REQ-005 SHALL provide parameter DEAD, default 4: dead-time clocks with both drive outputs low at each wave edge.
REQ-006 SHALL have one clock and an asynchronous active-low reset, named clk and rst_n.
REQ-007 clk  input  1  system clock, all state on rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 ch_en  input  NUM_CH  per-channel alarm request, level-sensitive.
REQ-010 ch_period  input  NUM_CH*CNT_W  per-channel full tone period in clocks; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-011 ch_pattern  input  NUM_CH*PAT_LEN  per-channel cadence mask; bit s=1 means sound during step s.
REQ-012 mute  input  1  forces silence; timers keep running.
REQ-013 piezo  output  1  registered positive drive.
REQ-014 piezo_n  output  1  registered complementary drive.
REQ-015 active_ch  output  $clog2(NUM_CH)  registered index of the sounding channel; 0 when silent.
REQ-016 tone_on  output  1  registered; high while a channel is selected and mute is low.

Function
REQ-017 Step timer SHALL count 0..TICK_CNT-1; on the terminal count it SHALL wrap to 0 and advance step modulo PAT_LEN (PAT_LEN-1 -> 0).
REQ-018 When ch_en is all-zero, tick count and step SHALL clear to 0 on the next clock; the first enabled cycle starts step 0 with a full TICK_CNT.
REQ-019 Channel i is a candidate when ch_en[i]=1, ch_pattern bit [step]=1 and ch_period >= 4; a period below 4 makes the channel never a candidate.
REQ-020 The selected channel SHALL be the lowest-index candidate, registered with one clock latency; no candidate means silent.
REQ-021 Tone counter SHALL count 0..P-1 and wrap, P being the selected period sampled at selection; wave=1 while count < P>>1, otherwise 0.
REQ-022 A selection change (including silent -> sounding) SHALL restart the tone counter at 0 and resample P; a ch_period change without a selection change takes effect at the next wrap.
REQ-023 On every wave edge both piezo and piezo_n SHALL be 0 for DEAD clocks, after which piezo=wave and piezo_n=~wave; they SHALL never both be 1.
REQ-024 When silent or mute=1, piezo=piezo_n=0 and tone_on=0 from the next clock; on unmute the tone counter SHALL restart at 0 and the dead-time window SHALL apply before the first drive.
REQ-025 If DEAD >= P>>1 for the selected period, the outputs SHALL stay low, with no error signalled.
REQ-026 Simultaneous step advance and selection change SHALL be resolved in one clock, with the new step's candidate set used.

Reset
REQ-027 On rst_n=0 all counters, step, selection and the dead-time counter SHALL clear asynchronously, and piezo=0, piezo_n=0, active_ch=0, tone_on=0.
REQ-028 After rst_n deasserts, the first step SHALL start at step 0 with a full tick interval.

Structure
REQ-029 Package piezo_pkg SHALL hold the parameter defaults and a minimum-period constant (4); there SHALL be no other typedefs.
REQ-030 The step timer SHALL be one sub-module, piezo_step_timer (inputs clr and tick-count limit; outputs step and step_adv).
REQ-031 Priority select, tone counter and dead-time logic SHALL reside in piezo_seq.

Verification (TICK_CNT=10, DEAD=2)
REQ-032 Single channel: ch_en=001, period=20, pattern=8'hFF -> piezo high 8 clocks, both low 2 clocks, piezo_n high 8 clocks, both low 2 clocks, repeating; active_ch=0.
REQ-033 Priority: ch_en=111, periods 20/40/60, pattern0=8'h0F, others 8'hFF -> steps 0-3 period 20 with active_ch=0; steps 4-7 period 40 with active_ch=1; tone counter restarts at each switch.
REQ-034 Cadence: ch_en=100, pattern=8'b10100000 -> tone_on high only during steps 5 and 7, each 10 clocks, then the pattern repeats.
REQ-035 Boundaries: period=3 -> silent; DEAD=10 with period=20 -> outputs stay low; mute pulsed mid-tone -> outputs low next clock and restart at count 0 on release.
REQ-036 Reset mid-tone: rst_n asserted asynchronously -> all outputs 0 immediately; on release, step 0 starts with a full 10-clock interval.

Source files
------------

// File: rtl/piezo_pkg.sv
// Shared defaults for the piezo alarm sequencer.
package piezo_pkg;

  localparam int unsigned NUM_CH_DEF   = 3;
  localparam int unsigned CNT_W_DEF    = 21;
  localparam int unsigned PAT_LEN_DEF  = 8;
  localparam int unsigned TICK_CNT_DEF = 6250000;
  localparam int unsigned DEAD_DEF     = 4;
  localparam int unsigned MIN_PERIOD   = 4;

endpackage

// File: rtl/piezo_step_timer.sv
// Cadence step timer: counts clocks per step and advances the pattern step index.
module piezo_step_timer
  import piezo_pkg::*;
#(
  parameter int unsigned PAT_LEN = PAT_LEN_DEF,
  parameter int unsigned TICK_W  = $clog2(TICK_CNT_DEF)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic [TICK_W-1:0]          tick_lim,
  output logic [$clog2(PAT_LEN)-1:0] step,
  output logic                       step_adv
);

  localparam int unsigned STEP_W = $clog2(PAT_LEN);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [STEP_W-1:0] step_q, step_d;

  always_comb begin
    tick_d   = tick_q;
    step_d   = step_q;
    step_adv = !clr && (tick_q == tick_lim);
    if (clr) begin
      tick_d = '0;
      step_d = '0;
    end else if (step_adv) begin
      // PAT_LEN is a power of two, so the natural wrap gives modulo PAT_LEN
      tick_d = '0;
      step_d = step_q + 1'b1;
    end else begin
      tick_d = tick_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
      step_q <= '0;
    end else begin
      tick_q <= tick_d;
      step_q <= step_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/piezo_seq.sv
// Multi-channel piezo alarm sequencer: priority channel select, tone generator
// and dead-time protected complementary drive.
module piezo_seq
  import piezo_pkg::*;
#(
  parameter int unsigned NUM_CH   = NUM_CH_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned PAT_LEN  = PAT_LEN_DEF,
  parameter int unsigned TICK_CNT = TICK_CNT_DEF,
  parameter int unsigned DEAD     = DEAD_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic [NUM_CH*CNT_W-1:0]   ch_period,
  input  logic [NUM_CH*PAT_LEN-1:0] ch_pattern,
  input  logic                      mute,
  output logic                      piezo,
  output logic                      piezo_n,
  output logic [$clog2(NUM_CH)-1:0] active_ch,
  output logic                      tone_on
);

  localparam int unsigned IDX_W  = $clog2(NUM_CH);
  localparam int unsigned STEP_W = $clog2(PAT_LEN);
  localparam int unsigned TICK_W = $clog2(TICK_CNT);
  localparam int unsigned AGE_W  = $clog2(DEAD + 2);

  logic [STEP_W-1:0]  step, step_nx;
  logic               step_adv;
  logic [PAT_LEN-1:0] pat [NUM_CH];
  logic [CNT_W-1:0]   per [NUM_CH];
  logic [NUM_CH-1:0]  cand;
  logic               cand_valid;
  logic [IDX_W-1:0]   cand_idx;

  logic               sel_valid_q, sel_valid_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   per_q, per_d;
  logic [CNT_W-1:0]   tone_q, tone_d;
  logic               wave_q, wave_d;
  logic               sound_q, sound_d;
  logic [AGE_W-1:0]   age_q, age_d;
  logic               piezo_q, piezo_d;
  logic               piezo_n_q, piezo_n_d;
  logic               tone_on_q, tone_on_d;
  logic [IDX_W-1:0]   active_ch_q, active_ch_d;

  logic               sel_chg;
  logic               sounding;
  logic [CNT_W-1:0]   half;
  logic               wave;
  logic               drive_ok;

  piezo_step_timer #(
    .PAT_LEN (PAT_LEN),
    .TICK_W  (TICK_W)
  ) u_step_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (ch_en == '0),
    .tick_lim (TICK_W'(TICK_CNT - 1)),
    .step     (step),
    .step_adv (step_adv)
  );

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign pat[g]  = ch_pattern[g*PAT_LEN +: PAT_LEN];
    assign per[g]  = ch_period[g*CNT_W +: CNT_W];
    assign cand[g] = ch_en[g] && pat[g][step_nx] && (per[g] >= CNT_W'(MIN_PERIOD));
  end

  // Candidates look at the step that will be current after this edge, so a
  // step advance and the resulting selection change land on the same clock.
  always_comb begin
    step_nx    = step_adv ? step + 1'b1 : step;
    cand_valid = |cand;
    cand_idx   = '0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (cand[IDX_W'(i - 1)]) begin
        cand_idx = IDX_W'(i - 1);
      end
    end
  end

  always_comb begin
    sel_valid_d = cand_valid;
    sel_d       = cand_idx;
    sel_chg     = (cand_valid != sel_valid_q) || (cand_idx != sel_q);
    per_d       = per_q;
    tone_d      = tone_q;
    if (sel_chg || mute || !sel_valid_q) begin
      tone_d = '0;
      per_d  = per[cand_idx];
    end else if (tone_q >= per_q - 1'b1) begin
      tone_d = '0;
      per_d  = per[sel_q];
    end else begin
      tone_d = tone_q + 1'b1;
    end
  end

  // age counts clocks since the last wave edge (or since sound started);
  // drive is allowed once DEAD clocks have elapsed at that level.
  always_comb begin
    sounding = sel_valid_q && !mute;
    half     = per_q >> 1;
    wave     = tone_q < half;
    sound_d  = sounding;
    wave_d   = wave;
    if (!sound_q || (wave != wave_q)) begin
      age_d = '0;
    end else if (age_q >= AGE_W'(DEAD)) begin
      age_d = age_q;
    end else begin
      age_d = age_q + 1'b1;
    end
    drive_ok    = sounding && (age_d >= AGE_W'(DEAD)) && (32'(half) > DEAD);
    piezo_d     = drive_ok && wave;
    piezo_n_d   = drive_ok && !wave;
    tone_on_d   = sounding;
    active_ch_d = sel_valid_q ? sel_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_valid_q <= 1'b0;
      sel_q       <= '0;
      per_q       <= '0;
      tone_q      <= '0;
      wave_q      <= 1'b0;
      sound_q     <= 1'b0;
      age_q       <= '0;
      piezo_q     <= 1'b0;
      piezo_n_q   <= 1'b0;
      tone_on_q   <= 1'b0;
      active_ch_q <= '0;
    end else begin
      sel_valid_q <= sel_valid_d;
      sel_q       <= sel_d;
      per_q       <= per_d;
      tone_q      <= tone_d;
      wave_q      <= wave_d;
      sound_q     <= sound_d;
      age_q       <= age_d;
      piezo_q     <= piezo_d;
      piezo_n_q   <= piezo_n_d;
      tone_on_q   <= tone_on_d;
      active_ch_q <= active_ch_d;
    end
  end

  assign piezo     = piezo_q;
  assign piezo_n   = piezo_n_q;
  assign tone_on   = tone_on_q;
  assign active_ch = active_ch_q;

endmodule

// File: tb/tb_piezo_seq.sv
// Directed bench for piezo_seq with TICK_CNT=10; a second instance uses DEAD=10.
module tb_piezo_seq;

  localparam int unsigned NCH = 3;
  localparam int unsigned CW  = 8;
  localparam int unsigned PL  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    ch_en;
  logic [NCH*CW-1:0] ch_period;
  logic [NCH*PL-1:0] ch_pattern;
  logic              mute;
  logic              piezo, piezo_n, tone_on;
  logic [1:0]        active_ch;
  logic              piezo_b, piezo_n_b, tone_on_b;
  logic [1:0]        active_ch_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  piezo_seq #(
    .NUM_CH   (NCH),
    .CNT_W    (CW),
    .PAT_LEN  (PL),
    .TICK_CNT (10),
    .DEAD     (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch_en      (ch_en),
    .ch_period  (ch_period),
    .ch_pattern (ch_pattern),
    .mute       (mute),
    .piezo      (piezo),
    .piezo_n    (piezo_n),
    .active_ch  (active_ch),
    .tone_on    (tone_on)
  );

  piezo_seq #(
    .NUM_CH   (NCH),
    .CNT_W    (CW),
    .PAT_LEN  (PL),
    .TICK_CNT (10),
    .DEAD     (10)
  ) dut_dt (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch_en      (ch_en),
    .ch_period  (ch_period),
    .ch_pattern (ch_pattern),
    .mute       (mute),
    .piezo      (piezo_b),
    .piezo_n    (piezo_n_b),
    .active_ch  (active_ch_b),
    .tone_on    (tone_on_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at cyc %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Expected {piezo, piezo_n} for tone count c of period p with dead time d,
  // counting from a wave edge at c=0.
  function automatic logic [1:0] drive(input int c, input int p, input int d);
    if (d >= p / 2) return 2'b00;
    if (c >= d && c < p / 2) return 2'b10;
    if (c >= p / 2 + d && c < p) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle(input int n);
    ch_en = '0;
    mute  = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    int t0, s0, k, n, st, s, p, c, a;
    logic on;

    rst_n      = 1'b0;
    ch_en      = '0;
    ch_period  = '0;
    ch_pattern = '0;
    mute       = 1'b0;
    repeat (2) tick();
    chk("rst_drv",    {piezo, piezo_n}, 2'b00);
    chk("rst_tone",   tone_on, 1'b0);
    chk("rst_active", active_ch, 2'd0);

    // Single channel, period 20, continuous pattern
    ch_period  = {8'd60, 8'd40, 8'd20};
    ch_pattern = {8'hFF, 8'hFF, 8'hFF};
    ch_en      = 3'b001;
    rst_n      = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 45; i++) begin
      tick();
      k = cyc - t0;
      c = (k >= 2) ? (k - 2) % 20 : 0;
      chk("single_drv",    {piezo, piezo_n}, (k >= 2) ? drive(c, 20, 2) : 2'b00);
      chk("single_tone",   tone_on, (k >= 2) ? 1'b1 : 1'b0);
      chk("single_active", active_ch, 2'd0);
      chk("dead10_drv",    {piezo_b, piezo_n_b}, 2'b00);
      chk("dead10_tone",   tone_on_b, (k >= 2) ? 1'b1 : 1'b0);
    end

    // Mute while piezo is high
    chk("premute_hi", piezo, 1'b1);
    mute = 1'b1;
    repeat (3) begin
      tick();
      chk("mute_drv",  {piezo, piezo_n}, 2'b00);
      chk("mute_tone", tone_on, 1'b0);
    end
    mute = 1'b0;
    s0 = cyc;
    for (int i = 0; i < 22; i++) begin
      tick();
      c = (cyc - 1 - s0) % 20;
      chk("unmute_drv",  {piezo, piezo_n}, drive(c, 20, 2));
      chk("unmute_tone", tone_on, 1'b1);
    end

    // Priority: channel 0 owns steps 0-3, channel 1 the rest
    idle(4);
    chk("idle_tone", tone_on, 1'b0);
    chk("idle_drv",  {piezo, piezo_n}, 2'b00);
    ch_pattern = {8'hFF, 8'hFF, 8'h0F};
    ch_en      = 3'b111;
    t0 = cyc;
    for (int i = 0; i < 100; i++) begin
      tick();
      n = cyc - t0 - 1;
      if (n == 0) begin
        chk("prio_tone0", tone_on, 1'b0);
        chk("prio_drv0",  {piezo, piezo_n}, 2'b00);
      end else begin
        st = (n / 10) % 8;
        if (st < 4) begin
          p = 20; a = 0;
          s = (n / 80) * 80;
          if (s == 0) s = 1;
        end else begin
          p = 40; a = 1;
          s = (n / 80) * 80 + 40;
        end
        c = (n - s) % p;
        chk("prio_active", active_ch, a);
        chk("prio_tone",   tone_on, 1'b1);
        chk("prio_drv",    {piezo, piezo_n}, drive(c, p, 2));
      end
    end

    // Cadence: channel 2 sounds only in steps 5 and 7
    idle(4);
    ch_period  = {8'd20, 8'd40, 8'd20};
    ch_pattern = {8'b1010_0000, 8'hFF, 8'hFF};
    ch_en      = 3'b100;
    t0 = cyc;
    for (int i = 0; i < 145; i++) begin
      tick();
      n  = cyc - t0 - 1;
      st = (n / 10) % 8;
      on = (n >= 1) && (st == 5 || st == 7);
      c  = n - (n / 10) * 10;
      chk("cad_tone",   tone_on, on);
      chk("cad_active", active_ch, on ? 2'd2 : 2'd0);
      chk("cad_drv",    {piezo, piezo_n}, on ? drive(c, 20, 2) : 2'b00);
    end

    // Period below minimum is never selected; period 4 is, but DEAD >= P>>1
    idle(4);
    ch_period  = {8'd20, 8'd40, 8'd3};
    ch_pattern = {8'hFF, 8'hFF, 8'hFF};
    ch_en      = 3'b001;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("p3_tone", tone_on, 1'b0);
      chk("p3_drv",  {piezo, piezo_n}, 2'b00);
    end
    ch_period = {8'd20, 8'd40, 8'd4};
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      tick();
      k = cyc - t0;
      chk("p4_tone", tone_on, (k >= 2) ? 1'b1 : 1'b0);
      chk("p4_drv",  {piezo, piezo_n}, 2'b00);
    end

    // Asynchronous reset in the middle of a high half-cycle
    idle(4);
    ch_period = {8'd20, 8'd40, 8'd20};
    ch_en     = 3'b001;
    repeat (7) tick();
    chk("prerst_hi", piezo, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_drv",    {piezo, piezo_n}, 2'b00);
    chk("arst_tone",   tone_on, 1'b0);
    chk("arst_active", active_ch, 2'd0);
    ch_pattern = {8'hFF, 8'hFF, 8'h02};
    repeat (2) tick();
    rst_n = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 25; i++) begin
      tick();
      n  = cyc - t0 - 1;
      on = (n >= 10) && (n <= 19);
      chk("post_rst_tone", tone_on, on);
      chk("post_rst_drv",  {piezo, piezo_n}, on ? drive(n - 10, 20, 2) : 2'b00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      total++;
      assert (!(piezo === 1'b1 && piezo_n === 1'b1)) else begin
        bad++;
        $error("FAIL both_high at cyc %0d: observed=11 expected=not 11", cyc);
      end
    end
  end

endmodule
